// File: rtl/skid_register.sv
// Pipeline register stage with valid/ready handshake, a 2-entry skid buffer, Enable and Flush.
// Optional stall counter is built only when SKID_REG_PERF_EN is defined.
module skid_register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
`ifdef SKID_REG_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_raw;
    logic             out_valid_raw;
    logic [1:0]       occ_q;

    // Handshake flags are flops; only the Enable gate is combinational.
    assign in_ready  = Enable & in_ready_raw;
    assign out_valid = Enable & out_valid_raw;
    assign out_data  = main_q;
    assign occupancy = occ_q;

    always_ff @(posedge CLK) begin
        if (!Reset || Flush) begin
            state         <= EMPTY;
            main_q        <= RESET_VALUE;
            skid_q        <= RESET_VALUE;
            in_ready_raw  <= 1'b1;
            out_valid_raw <= 1'b0;
            occ_q         <= 2'd0;
        end else if (Enable) begin
            unique case (state)
                EMPTY: begin
                    if (in_valid) begin
                        main_q        <= in_data;
                        state         <= ONE;
                        in_ready_raw  <= 1'b1;
                        out_valid_raw <= 1'b1;
                        occ_q         <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        main_q <= in_data;
                    end else if (in_valid) begin
                        // Downstream stalled: park the beat, main stays stable.
                        skid_q        <= in_data;
                        state         <= FULL;
                        in_ready_raw  <= 1'b0;
                        out_valid_raw <= 1'b1;
                        occ_q         <= 2'd2;
                    end else if (out_ready) begin
                        state         <= EMPTY;
                        in_ready_raw  <= 1'b1;
                        out_valid_raw <= 1'b0;
                        occ_q         <= 2'd0;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        main_q        <= skid_q;
                        state         <= ONE;
                        in_ready_raw  <= 1'b1;
                        out_valid_raw <= 1'b1;
                        occ_q         <= 2'd1;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    in_ready_raw  <= 1'b1;
                    out_valid_raw <= 1'b0;
                    occ_q         <= 2'd0;
                end
            endcase
        end
    end

`ifdef SKID_REG_PERF_EN
    logic [CNT_W-1:0] stall_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (v == {CNT_W{1'b1}}) ? v : v + one;
    endfunction

    // out_valid already carries the Enable gate, so a frozen stage does not count.
    always_ff @(posedge CLK) begin
        if (!Reset || Flush) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_skid_register.sv
// Bench for skid_register: directed scenarios plus random traffic against a queue model.
module tb_skid_register;
    localparam int             WIDTH = 8;
    localparam logic [7:0]     RV    = 8'h5A;
    localparam int             CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, en, flush, in_valid, out_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
`ifdef SKID_REG_PERF_EN
    logic [CNT_W-1:0] stall_count;
`endif

    skid_register #(.WIDTH(WIDTH), .RESET_VALUE(RV), .CNT_W(CNT_W)) dut (
        .CLK(clk), .Reset(rst_n), .Enable(en), .Flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy)
`ifdef SKID_REG_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the stage is a FIFO of at most two entries.
    logic [7:0] mq[$];
    logic [7:0] m_main = RV;
    int         m_stall = 0;
    bit         last_acc = 0, last_drop = 0;
    logic [7:0] out_log[$];
    logic [7:0] sent[$];
    bit         do_check = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit acc, xfer;
        acc = 0; xfer = 0;
        if (!rst_n || flush) begin
            mq.delete();
            m_main  = RV;
            m_stall = 0;
        end else if (en) begin
            acc  = in_valid && (mq.size() < 2);
            xfer = (mq.size() > 0) && out_ready;
            if (mq.size() > 0 && !out_ready && m_stall < (1 << CNT_W) - 1) m_stall++;
            if (xfer) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
            if (mq.size() > 0) m_main = mq[0];
        end
        last_acc  = acc;
        last_drop = !rst_n || flush;
    endtask

    task automatic tick();
        @(negedge clk);
        if (do_check) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, (en && mq.size() > 0)});
            check("in_ready", {31'd0, in_ready}, {31'd0, (en && mq.size() < 2)});
            check("occupancy", {30'd0, occupancy}, mq.size());
            check("out_data", {24'd0, out_data}, {24'd0, m_main});
`ifdef SKID_REG_PERF_EN
            check("stall_count", {28'd0, stall_count}, m_stall);
`endif
        end
        if (rst_n && !flush && out_valid && out_ready) out_log.push_back(out_data);
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Hold a pending beat until accepted; start a new one only when free.
    task automatic drive_in(input bit want, input logic [7:0] d);
        if (!(in_valid && !last_acc && !last_drop)) begin
            in_valid = want;
            in_data  = d;
        end
        if (in_valid && !(in_valid && !last_acc && !last_drop && sent.size() > 0 && sent[$] == in_data))
            ;
    endtask

    task automatic note_accept();
        if (last_acc) sent.push_back(in_data);
    endtask

    task automatic check_logs(input string tag);
        check({tag, "_count"}, out_log.size(), sent.size());
        for (int i = 0; i < out_log.size() && i < sent.size(); i++)
            if (out_log[i] !== sent[i]) check({tag, "_data"}, {24'd0, out_log[i]}, {24'd0, sent[i]});
        out_log.delete();
        sent.delete();
    endtask

    initial begin
        rst_n = 0; en = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
        // Test 1: reset two cycles
        tick(); tick();
        rst_n = 1;
        do_check = 1;
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_occ", {30'd0, occupancy}, 0);
        check("rst_out_data", {24'd0, out_data}, {24'd0, RV});

        // Test 2: back-to-back stream, full throughput
        out_log.delete();
        out_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1; in_data = i[7:0];
            tick();
            check("t2_accept", {31'd0, last_acc}, 1);
        end
        in_valid = 0;
        tick(); tick();
        check("t2_beats", out_log.size(), 16);
        for (int i = 0; i < out_log.size(); i++)
            check("t2_order", {24'd0, out_log[i]}, i + 1);

        // Test 3: fill skid, then drain in order
        out_ready = 0;
        in_valid = 1; in_data = 8'hA5; tick();
        in_data = 8'h3C; tick();
        in_valid = 0;
        check("t3_occ_full", {30'd0, occupancy}, 2);
        check("t3_in_ready", {31'd0, in_ready}, 0);
        check("t3_main", {24'd0, out_data}, 8'hA5);
        out_log.delete();
        out_ready = 1; tick(); tick(); tick();
        check("t3_n", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check("t3_first", {24'd0, out_log[0]}, 8'hA5);
            check("t3_second", {24'd0, out_log[1]}, 8'h3C);
        end

        // Test 4: flush from FULL drops the same-cycle input beat
        out_ready = 0;
        in_valid = 1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        check("t4_full", {30'd0, occupancy}, 2);
        flush = 1; in_valid = 1; in_data = 8'h77; tick();
        flush = 0; in_valid = 0;
        check("t4_occ", {30'd0, occupancy}, 0);
        check("t4_data", {24'd0, out_data}, {24'd0, RV});
        out_log.delete();
        out_ready = 1; tick(); tick(); tick();
        check("t4_no_beat", out_log.size(), 0);

        // Test 5: Enable dropped mid-stream
        out_log.delete(); sent.delete();
        out_ready = 1; last_acc = 0; last_drop = 1;
        for (int i = 0; i < 30; i++) begin
            en = !(i >= 8 && i < 13);
            drive_in(i < 24, 8'h30 + i[7:0]);
            tick();
            note_accept();
            if (i == 10) begin
                check("t5_ov_gated", {31'd0, out_valid}, 0);
                check("t5_ir_gated", {31'd0, in_ready}, 0);
                check("t5_occ_hold", {30'd0, occupancy}, 1);
            end
        end
        en = 1; in_valid = 0; tick(); tick(); tick();
        check_logs("t5");

`ifdef SKID_REG_PERF_EN
        // Test 6: stall counter saturates
        flush = 1; tick(); flush = 0;
        out_ready = 0; in_valid = 1; in_data = 8'h99; tick(); in_valid = 0;
        for (int i = 0; i < 20; i++) tick();
        check("t6_stall_sat", {28'd0, stall_count}, 15);
        flush = 1; tick(); flush = 0;
        check("t6_stall_clr", {28'd0, stall_count}, 0);
`endif

        // Random traffic against the model
        out_log.delete(); sent.delete();
        last_acc = 0; last_drop = 1;
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            drive_in($urandom_range(0, 9) < 7, 8'($urandom));
            tick();
            note_accept();
            if (last_drop) begin
                out_log.delete(); sent.delete();
            end
        end
        rst_n = 1; flush = 0; en = 1; in_valid = 0; out_ready = 1;
        tick(); tick(); tick();
        check_logs("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
